irrigation_sequencer: RTL and testbench

- Master FSM for the irrigation controller. It is the initiator side of the timer interface.
- Drives the phase code, irrigation type and the preset/load strobes into the countdown timer, then consumes the timer's expiry flag (clk_off) to advance phases.
- Sequences tank fill, the timed irrigation phase and the timed purge phase, and drives the pump, valve and drain enables.

---
 rtl/irrigation_sequencer_if.sv | 26 ++
 rtl/irrigation_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_irrigation_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/irrigation_sequencer_if.sv
// Timer handshake bundle between the irrigation sequencer (master) and the
// countdown timer (slave): phase code, latched type, preset/load strobes and
// the timer's expiry flag.
interface irrigation_sequencer_if;
  logic [1:0] state;              // 00 idle, 01 irrigate, 10 purge, 11 fill
  logic [1:0] irrigation_type;    // latched run type
  logic       pulse_transiction;  // timer latches presets
  logic       init_pulse;         // timer counters load
  logic       timer_done;         // timer clk_off, 1 = count at 00

  modport master (
    output state,
    output irrigation_type,
    output pulse_transiction,
    output init_pulse,
    input  timer_done
  );

  modport slave (
    input  state,
    input  irrigation_type,
    input  pulse_transiction,
    input  init_pulse,
    output timer_done
  );
endinterface

// File: rtl/irrigation_sequencer.sv
// Master FSM of the irrigation controller. Fills the tank, then runs the timed
// irrigate and purge phases through the countdown timer, and drives the pump,
// valve and drain enables. All outputs are registered and decoded from the
// next state so they line up with the state they describe.
module irrigation_sequencer #(
  parameter int unsigned GUARD_CYCLES = 2,  // 1..7, covers timer load latency
  parameter int unsigned MAX_REFILLS  = 3   // 1..7, refills allowed per run
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic [1:0]                    type_sel,
  input  logic                          tank_low,
  irrigation_sequencer_if.master        tmr,
  output logic                          pump_on,
  output logic                          valve_on,
  output logic                          drain_on,
  output logic                          busy,
  output logic                          error
);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StLoad,
    StArm,
    StGuard,
    StRun,
    StError
  } fsm_e;

  localparam logic       PhIrrigate = 1'b0;
  localparam logic       PhPurge    = 1'b1;
  localparam logic [2:0] GuardLast  = 3'(GUARD_CYCLES - 1);
  localparam logic [2:0] MaxRefills = 3'(MAX_REFILLS);

  fsm_e       fsm_q, fsm_d;
  logic       phase_q, phase_d;
  logic [2:0] guard_q, guard_d;
  logic [2:0] refill_q, refill_d;
  logic [1:0] type_q, type_d;

  logic [1:0] code_q, code_d;
  logic       pulse_q, pulse_d;
  logic       init_q, init_d;
  logic       pump_q, pump_d;
  logic       valve_q, valve_d;
  logic       drain_q, drain_d;
  logic       busy_q, busy_d;
  logic       error_q, error_d;

  logic       timed_now;
  logic       timed_next;
  logic       refill_req;

  assign timed_now  = (fsm_q == StLoad) || (fsm_q == StArm) ||
                      (fsm_q == StGuard) || (fsm_q == StRun);
  // Low tank only matters while irrigating; purge drains regardless.
  assign refill_req = timed_now && (phase_q == PhIrrigate) && tank_low;

  // Next-state logic: stop first, then refill, then per-state progress.
  always_comb begin
    fsm_d    = fsm_q;
    phase_d  = phase_q;
    guard_d  = guard_q;
    refill_d = refill_q;
    type_d   = type_q;

    if (stop) begin
      fsm_d   = StIdle;
      guard_d = 3'd0;
    end else if (refill_req) begin
      // Elapsed irrigate time is discarded; the phase restarts after FILL.
      if (refill_q == MaxRefills) begin
        fsm_d = StError;
      end else begin
        refill_d = refill_q + 3'd1;
        fsm_d    = StFill;
      end
    end else begin
      case (fsm_q)
        StIdle: begin
          if (start && !type_sel[1]) begin
            type_d   = type_sel;
            refill_d = 3'd0;
            phase_d  = PhIrrigate;
            fsm_d    = tank_low ? StFill : StLoad;
          end
        end
        StFill: begin
          if (!tank_low) begin
            fsm_d   = StLoad;
            phase_d = PhIrrigate;
          end
        end
        StLoad: fsm_d = StArm;
        StArm: begin
          fsm_d   = StGuard;
          guard_d = 3'd0;
        end
        StGuard: begin
          if (guard_q == GuardLast) begin
            fsm_d = StRun;
          end else begin
            guard_d = guard_q + 3'd1;
          end
        end
        StRun: begin
          if (tmr.timer_done) begin
            if (phase_q == PhIrrigate) begin
              fsm_d   = StLoad;
              phase_d = PhPurge;
            end else begin
              fsm_d = StIdle;
            end
          end
        end
        StError: fsm_d = StError;
        default: fsm_d = StIdle;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs match fsm_q.
  always_comb begin
    timed_next = (fsm_d == StLoad) || (fsm_d == StArm) ||
                 (fsm_d == StGuard) || (fsm_d == StRun);
    code_d     = 2'b00;
    if (fsm_d == StFill) begin
      code_d = 2'b11;
    end else if (timed_next) begin
      code_d = (phase_d == PhPurge) ? 2'b10 : 2'b01;
    end
    pulse_d = (fsm_d == StLoad);
    init_d  = (fsm_d == StArm);
    pump_d  = (fsm_d == StFill);
    valve_d = timed_next && (phase_d == PhIrrigate);
    drain_d = timed_next && (phase_d == PhPurge);
    busy_d  = (fsm_d != StIdle) && (fsm_d != StError);
    error_d = (fsm_d == StError);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q    <= StIdle;
      phase_q  <= PhIrrigate;
      guard_q  <= 3'd0;
      refill_q <= 3'd0;
      type_q   <= 2'b00;
      code_q   <= 2'b00;
      pulse_q  <= 1'b0;
      init_q   <= 1'b0;
      pump_q   <= 1'b0;
      valve_q  <= 1'b0;
      drain_q  <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      phase_q  <= phase_d;
      guard_q  <= guard_d;
      refill_q <= refill_d;
      type_q   <= type_d;
      code_q   <= code_d;
      pulse_q  <= pulse_d;
      init_q   <= init_d;
      pump_q   <= pump_d;
      valve_q  <= valve_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  assign tmr.state             = code_q;
  assign tmr.irrigation_type   = type_q;
  assign tmr.pulse_transiction = pulse_q;
  assign tmr.init_pulse        = init_q;
  assign pump_on               = pump_q;
  assign valve_on              = valve_q;
  assign drain_on              = drain_q;
  assign busy                  = busy_q;
  assign error                 = error_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer (GUARD_CYCLES=2, MAX_REFILLS=3).
// Inputs change 1 time unit after a rising edge; outputs are compared after
// the next rising edge has settled.
module tb_irrigation_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] type_sel = 2'b00;
  logic       tank_low = 1'b0;
  logic       pump_on, valve_on, drain_on, busy, error;

  int nchecks = 0;
  int nerrors = 0;

  irrigation_sequencer_if tmr_if ();

  irrigation_sequencer #(
    .GUARD_CYCLES (2),
    .MAX_REFILLS  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .type_sel (type_sel),
    .tank_low (tank_low),
    .tmr      (tmr_if.master),
    .pump_on  (pump_on),
    .valve_on (valve_on),
    .drain_on (drain_on),
    .busy     (busy),
    .error    (error)
  );

  always #5 clk = ~clk;

  // {state, type, pulse, init, pump, valve, drain, busy, error}
  logic [10:0] obs;
  assign obs = {tmr_if.state, tmr_if.irrigation_type, tmr_if.pulse_transiction,
                tmr_if.init_pulse, pump_on, valve_on, drain_on, busy, error};

  function automatic logic [10:0] eo(input logic [1:0] st, input logic [1:0] ty,
                                     input logic pt, input logic ip, input logic pu,
                                     input logic va, input logic dr, input logic bu,
                                     input logic er);
    return {st, ty, pt, ip, pu, va, dr, bu, er};
  endfunction

  task automatic check(input string tag, input logic [10:0] act, input logic [10:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %b want %b (st,ty,pt,ip,pu,va,dr,bu,er)", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tmr_if.timer_done = 1'b0;

    // Reset
    rst_n = 1'b0;
    step();
    step();
    check("reset", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Nominal sprinkler run; early timer_done ignored through the guard window
    tank_low = 1'b0;
    type_sel = 2'b00;
    start    = 1'b1;
    step();
    check("nom_load", obs, eo(2'b01, 2'b00, 1, 0, 0, 1, 0, 1, 0));
    start = 1'b0;
    tmr_if.timer_done = 1'b1;
    step();
    check("nom_arm", obs, eo(2'b01, 2'b00, 0, 1, 0, 1, 0, 1, 0));
    step();
    check("nom_guard1", obs, eo(2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 0));
    step();
    check("nom_guard2", obs, eo(2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 0));
    step();
    check("nom_run", obs, eo(2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 0));
    tmr_if.timer_done = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("nom_run_hold", obs, eo(2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 0));
    tmr_if.timer_done = 1'b1;
    step();
    check("purge_load", obs, eo(2'b10, 2'b00, 1, 0, 0, 0, 1, 1, 0));
    tmr_if.timer_done = 1'b0;
    step();
    check("purge_arm", obs, eo(2'b10, 2'b00, 0, 1, 0, 0, 1, 1, 0));
    step();
    step();
    step();
    check("purge_run", obs, eo(2'b10, 2'b00, 0, 0, 0, 0, 1, 1, 0));
    tmr_if.timer_done = 1'b1;
    step();
    check("purge_done", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tmr_if.timer_done = 1'b0;

    // Fill first
    tank_low = 1'b1;
    type_sel = 2'b01;
    start    = 1'b1;
    step();
    check("fill_enter", obs, eo(2'b11, 2'b01, 0, 0, 1, 0, 0, 1, 0));
    start = 1'b0;
    step();
    check("fill_hold", obs, eo(2'b11, 2'b01, 0, 0, 1, 0, 0, 1, 0));
    tank_low = 1'b0;
    step();
    check("fill_exit", obs, eo(2'b01, 2'b01, 1, 0, 0, 1, 0, 1, 0));
    stop = 1'b1;
    step();
    check("fill_stop", obs, eo(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    stop = 1'b0;

    // Refill limit: three refills allowed, the fourth locks in error
    type_sel = 2'b00;
    start    = 1'b1;
    step();
    check("ref_load0", obs, eo(2'b01, 2'b00, 1, 0, 0, 1, 0, 1, 0));
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step();
      check($sformatf("ref_arm%0d", r), obs, eo(2'b01, 2'b00, 0, 1, 0, 1, 0, 1, 0));
      tank_low = 1'b1;
      step();
      check($sformatf("ref_fill%0d", r), obs, eo(2'b11, 2'b00, 0, 0, 1, 0, 0, 1, 0));
      tank_low = 1'b0;
      step();
      check($sformatf("ref_reload%0d", r), obs, eo(2'b01, 2'b00, 1, 0, 0, 1, 0, 1, 0));
    end
    step();
    tank_low = 1'b1;
    step();
    check("ref_error", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1));
    tank_low = 1'b0;
    start    = 1'b1;
    step();
    check("ref_error_sticky", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1));
    start = 1'b0;
    stop  = 1'b1;
    step();
    check("ref_error_stop", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    stop = 1'b0;

    // Stop mid-RUN with simultaneous timer_done
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stop_run", obs, eo(2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 0));
    stop = 1'b1;
    tmr_if.timer_done = 1'b1;
    step();
    check("stop_idle", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    stop = 1'b0;
    tmr_if.timer_done = 1'b0;
    step();
    check("stop_no_purge", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    // Reserved type ignored; start ignored while busy
    type_sel = 2'b11;
    start    = 1'b1;
    step();
    check("reserved_start", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    type_sel = 2'b00;
    step();
    check("busy_load", obs, eo(2'b01, 2'b00, 1, 0, 0, 1, 0, 1, 0));
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start    = 1'b1;
    type_sel = 2'b01;
    step();
    check("busy_start_ignored", obs, eo(2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 0));
    start = 1'b0;

    // tank_low and timer_done together in RUN(irrigate): refill wins
    tank_low = 1'b1;
    tmr_if.timer_done = 1'b1;
    step();
    check("race_fill", obs, eo(2'b11, 2'b00, 0, 0, 1, 0, 0, 1, 0));
    tank_low = 1'b0;
    tmr_if.timer_done = 1'b0;
    step();
    check("race_reload", obs, eo(2'b01, 2'b00, 1, 0, 0, 1, 0, 1, 0));

    // Into purge; tank_low ignored there; then reset mid-purge
    for (int i = 0; i < 4; i++) step();
    tmr_if.timer_done = 1'b1;
    step();
    check("rst_purge_load", obs, eo(2'b10, 2'b00, 1, 0, 0, 0, 1, 1, 0));
    tmr_if.timer_done = 1'b0;
    tank_low = 1'b1;
    step();
    step();
    check("purge_ignores_low", obs, eo(2'b10, 2'b00, 0, 0, 0, 0, 1, 1, 0));
    tank_low = 1'b0;
    rst_n = 1'b0;
    step();
    check("reset_mid_purge", obs, eo(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    rst_n    = 1'b1;
    type_sel = 2'b01;
    start    = 1'b1;
    step();
    check("post_reset_drip", obs, eo(2'b01, 2'b01, 1, 0, 0, 1, 0, 1, 0));
    start = 1'b0;
    stop  = 1'b1;
    step();
    check("final_stop", obs, eo(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    stop = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
